// File: rtl/booth_pkg.sv
// booth_pkg: shared state, add/sub control and Booth pair encodings
package booth_pkg;
  typedef enum logic [1:0] {IDLE, EVAL, SHIFT, DONE} state_t;
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;
  localparam logic [1:0] PAIR_ADD = 2'b01;
  localparam logic [1:0] PAIR_SUB = 2'b10;
endpackage

// File: rtl/booth_addsub.sv
// booth_addsub: registered modulo-2^N adder/subtractor
module booth_addsub #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ctrl,
  output logic [N-1:0] o
);
  always_ff @(posedge clk) o <= ctrl ? a - b : a + b;
endmodule

// File: rtl/booth_mult_ctrl.sv
// booth_mult_ctrl: radix-2 Booth signed multiplier sequencer
module booth_mult_ctrl
  import booth_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   mcand,
  input  logic [W-1:0]   mplier,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);
  localparam int CW = $clog2(W + 1);
  state_t state, state_n;
  logic [W:0] a_r, m_r, alu_o, a_nx;
  logic [W-1:0] q_r;
  logic q_1, op_pend, alu_ctrl;
  logic [CW-1:0] cnt;
  logic [1:0] pair;
  assign pair = {q_r[0], q_1};
  assign a_nx = op_pend ? alu_o : a_r;
  booth_addsub #(.N(W + 1)) u_addsub (
    .clk (clk),
    .a   (a_r),
    .b   (m_r),
    .ctrl(alu_ctrl),
    .o   (alu_o)
  );
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state == IDLE  ? (start ? EVAL : IDLE) :
              state == EVAL  ? SHIFT :
              state == SHIFT ? (cnt == CW'(1) ? DONE : EVAL) : IDLE;
  end
  always_comb begin
    busy     = state != IDLE;
    done     = state == DONE;
    alu_ctrl = pair == PAIR_SUB ? ALU_SUB : ALU_ADD;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      q_r     <= '0;
      q_1     <= 1'b0;
      m_r     <= '0;
      cnt     <= '0;
      op_pend <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_r <= '0;
          q_r <= mplier;
          q_1 <= 1'b0;
          m_r <= {mcand[W-1], mcand};
          cnt <= CW'(W);
        end
        EVAL: op_pend <= pair == PAIR_ADD || pair == PAIR_SUB;
        SHIFT: begin
          // arithmetic shift of {A', Q, Q_1}; product takes the low 2W bits
          a_r <= {a_nx[W], a_nx[W:1]};
          q_r <= {a_nx[0], q_r[W-1:1]};
          q_1 <= q_r[0];
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) product <= {a_nx, q_r[W-1:1]};
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/booth_mult_ctrl.md
# booth_mult_ctrl

Sequencer for radix-2 Booth signed multiplication, built around a registered add/sub unit. It accepts a multiplicand and multiplier on a start strobe and drives the add/sub unit once per Booth step. It performs the arithmetic shift-right on the {A, Q, Q_1} register and presents a 2W-bit signed product with a one-cycle done pulse. The block is the top-level control of the Booth multiplier path.

## Interface
- W, default 4: operand width in bits, signed two's complement; W ≥ 2.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- mcand  in  W  multiplicand M, signed; captured on start accept.
- mplier  in  W  multiplier, signed; captured on start accept.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse in DONE state.
- product  out  2W  signed result; holds until the next done.

## Operation
- Internal registers: A (W+1 bits), Q (W), Q_1 (1), M (W+1, sign-extended mcand), cnt (⌈log2(W+1)⌉ bits), op_pend (1).
- A is W+1 bits so that A−M cannot overflow for M = −2^(W−1).
- All add/sub arithmetic is modulo 2^(W+1).
- FSM states: IDLE, EVAL, SHIFT, DONE.
- IDLE: on start=1, load A=0, Q=mplier, Q_1=0, M=sext(mcand), cnt=W, then go to EVAL. start=0 stays in IDLE.
- EVAL: decode {Q[0],Q_1}:
  - 01: drive the add/sub unit with (A, M, ADD) and set op_pend=1.
  - 10: drive (A, M, SUB) and set op_pend=1.
  - 00/11: set op_pend=0; the unit's inputs are don't-care.
  - Always go to SHIFT.
- SHIFT:
  - A' = op_pend ? unit result : A.
  - Perform an arithmetic right shift of {A',Q,Q_1} by 1; A's MSB replicates.
  - cnt−1; if the new cnt is 0, go to DONE, else go to EVAL.
- On the SHIFT→DONE edge, product ← low 2W bits of the shifted {A,Q}.
- DONE: done=1 for exactly one cycle, then go unconditionally to IDLE.
- start in EVAL, SHIFT or DONE is ignored. Inputs are not re-sampled mid-operation.
- Back-to-back: start held high is accepted in the IDLE cycle following DONE.
- product is not cleared on accept; the old value stays visible until overwritten.

## Timing
- The accept edge is t0. The state is EVAL at t0+1, SHIFT at t0+2, and so on.
- Each Booth step takes exactly 2 cycles, whether or not an add/sub is issued, so latency is deterministic.
- done is high and product is valid in the cycle following edge t0+2W, i.e. 2W cycles after accept (8 for W=4).
- busy rises the cycle after accept and stays high through DONE. Minimum start-to-start period is 2W+2 cycles.
- Add/sub unit latency is exactly 1 cycle: the result registered at the end of EVAL is consumed in SHIFT.
- Reset values: state=IDLE, busy=0, done=0, product=0, A/Q/Q_1/M/cnt/op_pend=0.
- The add/sub unit's output register needs no reset; it is never consumed without a preceding EVAL.
- rst mid-operation aborts the current operation. The next cycle shows IDLE with all outputs at reset values, and no done is issued.
- rst has priority over start in the same cycle.

## Structure
- Package booth_pkg holds:
  - the state enum (IDLE, EVAL, SHIFT, DONE);
  - the unit control encodings ALU_ADD = 1'b0 and ALU_SUB = 1'b1;
  - the Booth pair decode constants (2'b01 add, 2'b10 sub).
- Sub-module booth_addsub, parameter width N (instantiated with N=W+1):
  - inputs a, b, ctrl; output o;
  - o registered on posedge clk; ctrl 0 → a+b, ctrl 1 → a−b, modulo 2^N;
  - no reset.
- booth_mult_ctrl contains the FSM, the shift register, the counter and the product register.

## Test plan
- W=4, mcand=3, mplier=2, start pulse → done exactly 8 cycles after accept, product=0x06, busy high for 9 cycles.
- mcand=−3 (0xD), mplier=2 → product=0xFA; mcand=7, mplier=−8 → product=0xC8.
- mcand=−8, mplier=−8 → product=0x40 (most-negative case, no overflow); mcand=0, mplier=5 → product=0x00.
- start pulsed high at cycles 3 and 7 after accept, with new operands → ignored; first result correct; no second done until a new start in IDLE.
- start held high continuously with mcand=2, mplier=3 → done pulses every 10 cycles, product=0x06 each time.
- rst asserted 4 cycles after accept → next cycle busy=0, done=0, product=0. No done follows. A new start then yields the correct result.
